fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Holds the PC and keeps at most one request outstanding to a variable-latency instruction
// memory. It honours stall and branch redirect. A NOP (all zeros) is presented whenever no
// instruction is ready, so the decode register captures a bubble.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   stall_f               downstream not accepting this cycle
//   redirect, redirect_pc taken branch/jump and its target (bits [1:0] ignored)
//   imem_req, imem_addr   one-cycle request strobe and address
//   imem_rvalid, imem_rdata  response strobe and instruction word
//   fetch_valid           instr_f/pc_f/pc_plus4_f hold a real instruction
//   instr_f, pc_f, pc_plus4_f  fetch-stage values (zero when fetch_valid=0)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_f,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StValid} state_e;

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_buf_q, instr_buf_d;
    logic        squash_q, squash_d;

    logic [31:0] target_pc;
    logic [31:0] pc_next_seq;

    assign target_pc   = {redirect_pc[31:2], 2'b00};
    assign pc_next_seq = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pc_q        <= ResetPcAligned;
            instr_buf_q <= 32'd0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_buf_q <= instr_buf_d;
            squash_q    <= squash_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_buf_d = instr_buf_q;
        squash_d    = squash_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                // The request to the old PC still goes out; its response gets squashed.
                state_d = StWait;
                if (redirect) begin
                    pc_d     = target_pc;
                    squash_d = 1'b1;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (squash_q || redirect) begin
                        squash_d = 1'b0;
                        state_d  = StReq;
                    end else begin
                        instr_buf_d = imem_rdata;
                        state_d     = StValid;
                    end
                end
                if (redirect) begin
                    pc_d = target_pc;
                    // Response still in flight belongs to the old path.
                    if (!imem_rvalid) begin
                        squash_d = 1'b1;
                    end
                end
            end
            StValid: begin
                // Redirect beats stall: the buffered instruction is simply dropped.
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = StReq;
                end else if (!stall_f) begin
                    pc_d    = pc_next_seq;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend on registered state only, so they stay glitch-free.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = 32'd0;
        fetch_valid = 1'b0;
        instr_f     = 32'd0;
        pc_f        = 32'd0;
        pc_plus4_f  = 32'd0;
        if (state_q == StReq) begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
        end
        if (state_q == StValid) begin
            fetch_valid = 1'b1;
            instr_f     = instr_buf_q;
            pc_f        = pc_q;
            pc_plus4_f  = pc_next_seq;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory model answers requests with data derived
// from the address. The reference model is the expected stream of delivered instructions:
// sequential from the last restart point (reset or redirect target). A monitor pops that
// stream whenever the DUT hands over an instruction.
module tb_fetch_unit;

    localparam logic [31:0] DataKey = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_n;
    logic        stall_f;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    wire         imem_rvalid;
    wire  [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;

    // Memory model outputs and manual override for injecting stray/late responses.
    logic        mem_en;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        man_rvalid;
    logic [31:0] man_rdata;
    logic        stray_en;
    logic        rand_lat;
    int          mem_lat;

    assign imem_rvalid = mem_en ? m_rvalid : man_rvalid;
    assign imem_rdata  = mem_en ? m_rdata : man_rdata;

    fetch_unit u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall_f     (stall_f),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .fetch_valid (fetch_valid),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pc_plus4_f  (pc_plus4_f)
    );

    // Second instance for the PC wrap-around case at reset.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall_f     (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'd0),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .fetch_valid (w_valid),
        .instr_f     (w_instr),
        .pc_f        (w_pc),
        .pc_plus4_f  (w_pc4)
    );

    int checks   = 0;
    int failures = 0;
    int accepted = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ DataKey;
        e.pc4   = pc + 32'd4;
        return e;
    endfunction

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(mk({pc[31:2], 2'b00}));
    endtask

    task automatic tick();
        exp_t last;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q.size() < 4) begin
            last = exp_q[exp_q.size() - 1];
            exp_q.push_back(mk(last.pc + 32'd4));
        end
    endtask

    task automatic wait_req(input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (imem_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- memory model (main DUT) ----------------
    initial begin
        bit          pending;
        int          cnt;
        logic [31:0] paddr;
        pending  = 0;
        cnt      = 0;
        paddr    = 32'd0;
        m_rvalid = 1'b0;
        m_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            m_rvalid = 1'b0;
            if (!reset_n) begin
                pending = 0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt <= 0) begin
                        m_rvalid = 1'b1;
                        m_rdata  = paddr ^ DataKey;
                        pending  = 0;
                    end
                end else if (stray_en && !imem_req && $urandom_range(0, 7) == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = $urandom;
                end
                if (imem_req) begin
                    chk("one_outstanding", {31'd0, pending}, 32'd0);
                    pending = 1;
                    paddr   = imem_addr;
                    cnt     = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                end
            end
        end
    end

    // ---------------- memory model (wrap DUT), latency 1 ----------------
    initial begin
        logic        w_seen;
        logic [31:0] w_lat_addr;
        w_seen     = 1'b0;
        w_lat_addr = 32'd0;
        w_rvalid   = 1'b0;
        w_rdata    = 32'd0;
        forever begin
            @(negedge clk);
            w_rvalid   = w_seen;
            w_rdata    = w_lat_addr ^ DataKey;
            w_seen     = w_req;
            w_lat_addr = w_addr;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                chk("reset_outputs_zero",
                    {31'd0, |{fetch_valid, imem_req, imem_addr, instr_f, pc_f, pc_plus4_f}}, 32'd0);
            end else if (fetch_valid) begin
                if (!redirect) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q[0];
                        chk("sb_pc_f", pc_f, e.pc);
                        chk("sb_instr_f", instr_f, e.instr);
                        chk("sb_pc_plus4_f", pc_plus4_f, e.pc4);
                        if (!stall_f) begin
                            void'(exp_q.pop_front());
                            accepted++;
                        end
                    end
                end
            end else begin
                chk("bubble_zero", {31'd0, |{instr_f, pc_f, pc_plus4_f}}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ok;
        int req_cyc[3];
        int nreq;
        int seen;
        logic [31:0] tgt;

        reset_n     = 1'b0;
        stall_f     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        mem_en      = 1'b1;
        man_rvalid  = 1'b0;
        man_rdata   = 32'd0;
        stray_en    = 1'b0;
        rand_lat    = 1'b0;
        mem_lat     = 1;
        restart(32'd0);
        repeat (3) tick();

        // Latency 1, no stall: one request every third cycle to 0, 4, 8.
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req(20, ok);
            chk("t1_req_seen", ok, 1);
            chk("t1_req_addr", imem_addr, 32'(k * 4));
            req_cyc[k] = cyc;
        end
        chk("t1_cadence_a", req_cyc[1] - req_cyc[0], 3);
        chk("t1_cadence_b", req_cyc[2] - req_cyc[1], 3);

        // Latency 4, stall held for 5 VALID cycles at pc 0x8.
        reset_n = 1'b0;
        mem_lat = 4;
        restart(32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_req(20, ok);
            if (ok == 0 || imem_addr == 32'h8) break;
        end
        chk("t2_req8_seen", ok, 1);
        chk("t2_req8_addr", imem_addr, 32'h8);
        stall_f = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_valid) break;
        end
        chk("t2_valid", {31'd0, fetch_valid}, 32'd1);
        chk("t2_stall_no_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_valid", {31'd0, fetch_valid}, 32'd1);
            chk("t2_stall_pc", pc_f, 32'h8);
            chk("t2_stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        stall_f = 1'b0;
        tick();
        chk("t2_req_after_stall", {31'd0, imem_req}, 32'd1);
        chk("t2_req_addr_c", imem_addr, 32'hC);

        // Redirect in WAIT before the response: response discarded, refetch at 0x100.
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        restart(32'h100);
        tick();
        redirect = 1'b0;
        seen     = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (imem_req) begin
                seen = 1;
                break;
            end
            chk("t3_squash_no_valid", {31'd0, fetch_valid}, 32'd0);
        end
        chk("t3_req_seen", seen, 1);
        chk("t3_req_addr", imem_addr, 32'h100);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (fetch_valid) break;
        end
        chk("t3_valid", {31'd0, fetch_valid}, 32'd1);
        chk("t3_pc_f", pc_f, 32'h100);

        // Redirect beats stall in VALID; target low bits dropped.
        stall_f     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        restart(32'h203);
        tick();
        stall_f  = 1'b0;
        redirect = 1'b0;
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_req_addr", imem_addr, 32'h200);

        // PC wrap from RESET_PC = 0xFFFF_FFFC on the second instance.
        reset_n = 1'b0;
        mem_lat = 1;
        restart(32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        nreq    = 0;
        seen    = 0;
        for (int i = 0; i < 20 && nreq < 2; i++) begin
            tick();
            if (w_req) begin
                if (nreq == 0) chk("t5_first_addr", w_addr, 32'hFFFF_FFFC);
                else chk("t5_wrap_addr", w_addr, 32'h0);
                nreq++;
            end
            if (w_valid && seen == 0) begin
                chk("t5_pc_f", w_pc, 32'hFFFF_FFFC);
                chk("t5_pc_plus4_wrap", w_pc4, 32'h0);
                chk("t5_instr_f", w_instr, 32'hFFFF_FFFC ^ DataKey);
                seen = 1;
            end
        end
        chk("t5_two_reqs", nreq, 2);
        chk("t5_valid_seen", seen, 1);

        // Reset while VALID clears outputs at once; late responses after release are ignored.
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fetch_valid) break;
        end
        chk("t6_valid_before_reset", {31'd0, fetch_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, fetch_valid}, 32'd0);
        chk("t6_async_instr", instr_f, 32'd0);
        chk("t6_async_pc", pc_f, 32'd0);
        restart(32'd0);
        tick();
        reset_n    = 1'b1;
        mem_en     = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_req_addr", imem_addr, 32'd0);
        tick();
        mem_en     = 1'b1;
        man_rvalid = 1'b0;
        tick();
        chk("t6_valid", {31'd0, fetch_valid}, 32'd1);
        chk("t6_instr", instr_f, DataKey);

        // Randomized traffic against the scoreboard.
        reset_n  = 1'b0;
        rand_lat = 1'b1;
        stray_en = 1'b1;
        restart(32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        wait_req(10, ok);
        chk("rand_first_req", ok, 1);
        accepted = 0;
        for (int i = 0; i < 3000; i++) begin
            stall_f = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 99) < 8) begin
                if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                else tgt = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
                redirect    = 1'b1;
                redirect_pc = tgt;
                restart(tgt);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        stall_f  = 1'b0;
        redirect = 1'b0;
        tick();
        chk("rand_progress", {31'd0, accepted >= 50}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
